node_mac_accumulator: RTL
=========================

// Module: node_mac_accumulator
// PURPOSE
//  Downstream consumer of the input node timer. Each cycle the timer advances input_num under coef_ready,
//  this block multiplies the indexed input value by its coefficient and accumulates the product.
//  When the timer reports n_start_done, it adds the node bias, rescales, applies ReLU with saturation,
//  and presents one node result on a valid/ready handshake to the output layer.
// PARAMETERS
//  DATA_W     8   signed width of input_val, coef_val, bias (Q3.4 fixed point)
//  FRAC_BITS  4   fractional bits of every DATA_W operand
//  ACC_W      24  signed accumulator width (>= 2*DATA_W + log2(MAX_INPUTS))
//  MAX_INPUTS 64  largest legal max_input
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  n_rst         in   1       asynchronous active-low reset
//  start         in   1       one-cycle pulse: clear accumulator, begin a new node
//  max_input     in   7       number of input/coef pairs for this node (0..MAX_INPUTS)
//  coef_ready    in   1       input_val/coef_val/input_num valid this cycle (same signal the timer counts on)
//  input_num     in   7       index of current pair, from the timer
//  n_start_done  in   1       timer has issued all max_input pairs
//  input_val     in   DATA_W  signed activation for index input_num
//  coef_val      in   DATA_W  signed weight for index input_num
//  bias          in   DATA_W  signed node bias, sampled on start
//  out_ready     in   1       output layer accepts node_out
//  node_out      out  DATA_W  result, unsigned-valued 0..2^(DATA_W-1)-1 after ReLU/saturation
//  node_valid    out  1       node_out valid; held until out_ready
//  busy          out  1       high in ACCUM, DRAIN, FINISH
//  seq_err       out  1       sticky: pair arrived out of order; cleared by start or reset
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, prod_reg=0, prod_vld=0, count=0, node_out=0, node_valid=0, busy=0, seq_err=0.
//  FSM IDLE -> ACCUM on start (acc<=0, count<=0, seq_err<=0, bias latched; max_input clamped to MAX_INPUTS).
//  ACCUM: a pair is accepted when coef_ready=1 && count<max_input && input_num==count.
//   Stage 1 registers prod_reg=input_val*coef_val (2*DATA_W signed) and sets prod_vld. count++.
//   Stage 2 acc <= acc + sign-extended prod_reg when prod_vld. Latency: product reaches acc 2 cycles after accept.
//   If coef_ready=1 && count<max_input && input_num!=count, the pair is dropped and seq_err<=1.
//   coef_ready while count==max_input is ignored.
//  ACCUM -> DRAIN when n_start_done=1 && count==max_input. If max_input=0, start goes straight to DRAIN.
//  DRAIN: one cycle so the last prod_reg lands in acc. Then -> FINISH.
//  FINISH (1 cycle): s = (acc + (bias<<<FRAC_BITS)) >>> FRAC_BITS (arithmetic shift).
//   node_out <= s<0 ? 0 : (s>2^(DATA_W-1)-1 ? 2^(DATA_W-1)-1 : s). node_valid<=1. Then -> HOLD.
//  HOLD: node_out/node_valid stable until out_ready=1. Then node_valid<=0 and -> IDLE.
//   If out_ready is already high on the cycle node_valid rises, the transfer completes at the next edge.
//  start during ACCUM/DRAIN: abort the current node and restart cleanly. Any in-flight product is discarded.
//  start during FINISH/HOLD: ignored.
//  n_rst low at any time: immediate return to reset values; no partial result is emitted.
//  Accumulator never overflows for legal max_input with ACC_W=24. No wrap handling is required.
// STRUCTURE
//  Shared package nn_pkg: DATA_W, FRAC_BITS, ACC_W, MAX_INPUTS constants;
//   typedef enum logic [2:0] {IDLE,ACCUM,DRAIN,FINISH,HOLD} mac_state_t; typedef logic signed [DATA_W-1:0] q_t.
//  One sub-module: relu_saturate (combinational ACC_W -> DATA_W scale/ReLU/clamp), reused by the output layer.
//  FSM, accept counter and 2-stage MAC pipeline stay in this module.
// TESTING
//  1. Reset mid-ACCUM after 2 pairs -> all outputs 0, state IDLE. A new start then produces a correct result.
//  2. start, bias=0, max_input=4, pairs (16,16)x4 [1.0*1.0], input_num 0..3, n_start_done after 4th
//     -> node_valid with node_out=64 (4.0). Held 3 cycles while out_ready=0; drops 1 cycle after out_ready=1.
//  3. max_input=0, bias=0x18 (1.5) -> node_out=0x18 valid 3 cycles after start.
//     Same with bias=0xE8 (-1.5) -> node_out=0.
//  4. max_input=64, all pairs (127,127) -> node_out=127 (saturated), seq_err=0.
//     Repeat after a coef_ready gap of 1 cycle mid-stream -> same result.
//  5. max_input=4, send input_num 0,2 (skip 1) -> seq_err=1, pair 2 dropped.
//     A subsequent start clears seq_err=0.
//  6. start pulse in ACCUM after 2 pairs, then 4 fresh pairs of (16,32) -> node_out=128 clamped to 127.
//     Only the new pairs contribute.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared fixed-point widths, MAC state encoding and operand type for the node layer
package nn_pkg;
  localparam int DATA_W     = 8;
  localparam int FRAC_BITS  = 4;
  localparam int ACC_W      = 24;
  localparam int MAX_INPUTS = 64;
  localparam int CNT_W      = 7;
  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, FINISH, HOLD} mac_state_t;
  typedef logic signed [DATA_W-1:0] q_t;
endpackage

// File: rtl/relu_saturate.sv
// relu_saturate: rescale a fixed-point accumulator sum, apply ReLU and clamp to the positive q_t range
module relu_saturate
  import nn_pkg::*;
(
  input  logic signed [ACC_W-1:0] sum,
  output q_t                      q
);
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  logic signed [ACC_W-1:0] s;
  assign s = sum >>> FRAC_BITS;
  assign q = s < 0 ? '0 : (s > Q_MAX ? Q_MAX[DATA_W-1:0] : s[DATA_W-1:0]);
endmodule

// File: rtl/node_mac_accumulator.sv
// node_mac_accumulator: in-order 2-stage MAC over timer-indexed pairs, bias/ReLU finish, valid/ready result
module node_mac_accumulator
  import nn_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [CNT_W-1:0] max_input,
  input  logic             coef_ready,
  input  logic [CNT_W-1:0] input_num,
  input  logic             n_start_done,
  input  q_t               input_val,
  input  q_t               coef_val,
  input  q_t               bias,
  input  logic             out_ready,
  output q_t               node_out,
  output logic             node_valid,
  output logic             busy,
  output logic             seq_err
);
  mac_state_t                 state;
  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] prod_reg;
  logic                       prod_vld;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           max_r;
  q_t                         bias_r;
  logic [CNT_W-1:0]           max_clamped;
  logic                       restart;
  logic                       pending;
  logic                       accept;
  logic signed [ACC_W-1:0]    sum;
  q_t                         relu_q;
  assign max_clamped = max_input > CNT_W'(MAX_INPUTS) ? CNT_W'(MAX_INPUTS) : max_input;
  assign restart     = start && (state == IDLE || state == ACCUM || state == DRAIN);
  assign pending     = state == ACCUM && coef_ready && count < max_r;
  assign accept      = pending && input_num == count;
  assign sum         = acc + ({{(ACC_W-DATA_W){bias_r[DATA_W-1]}}, bias_r} <<< FRAC_BITS);
  assign busy        = state == ACCUM || state == DRAIN || state == FINISH;
  relu_saturate u_relu (.sum(sum), .q(relu_q));
  // restart sits after the stage-2 add so its clear wins and any in-flight product is dropped
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      acc        <= '0;
      prod_reg   <= '0;
      prod_vld   <= 1'b0;
      count      <= '0;
      max_r      <= '0;
      bias_r     <= '0;
      node_out   <= '0;
      node_valid <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      prod_vld <= 1'b0;
      if (prod_vld) acc <= acc + {{(ACC_W-2*DATA_W){prod_reg[2*DATA_W-1]}}, prod_reg};
      if (restart) begin
        state   <= max_clamped == '0 ? DRAIN : ACCUM;
        acc     <= '0;
        count   <= '0;
        seq_err <= 1'b0;
        bias_r  <= bias;
        max_r   <= max_clamped;
      end else begin
        case (state)
          ACCUM: begin
            if (accept) begin
              prod_reg <= input_val * coef_val;
              prod_vld <= 1'b1;
              count    <= count + 1'b1;
            end else if (pending) seq_err <= 1'b1;
            if (n_start_done && count == max_r) state <= DRAIN;
          end
          DRAIN: state <= FINISH;
          FINISH: begin
            node_out   <= relu_q;
            node_valid <= 1'b1;
            state      <= HOLD;
          end
          HOLD: if (out_ready) begin
            node_valid <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
